demux_16_sequencer: RTL



---
 rtl/demux_16_sequencer.sv | 108 ++++++++++
 1 files changed

// File: rtl/demux_16_sequencer.sv
// demux_16_sequencer: takes a serial frame of up to 16 bits over a valid/ready
// handshake and presents each bit on the demux data input `i`, together with its
// channel select `s`. Each bit is held for HOLD_CYCLES cycles, and `i` returns to 0
// for at least one cycle between consecutive bits.
module demux_16_sequencer #(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned LAST_CH     = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [3:0] s,
  output logic       i,
  output logic       busy,
  output logic       frame_done,
  output logic [3:0] ch_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);
  localparam logic [3:0] LAST      = 4'(LAST_CH);

  state_t     state;
  logic [7:0] hold_cnt;

  // Frame sequencer: all outputs are registered and derived from the next state,
  // so din_ready never depends combinationally on din_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      s          <= '0;
      i          <= 1'b0;
      din_ready  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ch_idx     <= '0;
    end else if (abort) begin
      // Abort beats start and any pending transfer; s is left untouched
      // because i=0 already forces every demux output low.
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      i          <= 1'b0;
      din_ready  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ch_idx     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_WAIT;
            ch_idx    <= '0;
            busy      <= 1'b1;
            din_ready <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (din_valid) begin
            state     <= ST_HOLD;
            s         <= ch_idx;
            i         <= din;
            hold_cnt  <= HOLD_INIT;
            din_ready <= 1'b0;
          end else begin
            i <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt != 8'd0) begin
            hold_cnt <= hold_cnt - 8'd1;
          end else begin
            // Drop i before the next channel so no bit lands on the wrong output.
            i <= 1'b0;
            if (ch_idx != LAST) begin
              state     <= ST_WAIT;
              ch_idx    <= ch_idx + 4'd1;
              din_ready <= 1'b1;
            end else begin
              state      <= ST_DONE;
              ch_idx     <= '0;
              frame_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
